// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined CPU: widths, the bubble
// encoding, opcode constants and the IF/ID pipeline record.
package cpu_pkg;

    localparam int PC_W    = 12;
    localparam int INSTR_W = 16;
    localparam int CNT_W   = 16;

    // Bubble: ADDI r8 = r8 + 0; r8 is never used by programs.
    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h6808;

    localparam logic [3:0] OP_LDA  = 4'b0000;
    localparam logic [3:0] OP_STA  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_ADDI = 4'b0110;
    localparam logic [3:0] OP_SUBI = 4'b0111;
    localparam logic [3:0] OP_BNE  = 4'b1001;

    typedef struct packed {
        logic [INSTR_W-1:0] instruction;
        logic [PC_W-1:0]    pc;
        logic [PC_W-1:0]    pc_plus1;
        logic               valid;
    } ifid_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. flush inserts a bubble while keeping the
// previous pc fields; hold freezes every field; otherwise it loads d.
module if_id_reg
    import cpu_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  hold,
    input  logic  flush,
    input  ifid_t d,
    output ifid_t q
);

    ifid_t q_r;
    ifid_t next_s;

    // Select the next register contents; flush outranks hold.
    always_comb begin
        next_s = q_r;
        if (flush) begin
            next_s.instruction = NOP_INSTR;
            next_s.valid       = 1'b0;
        end else if (hold) begin
            next_s = q_r;
        end else begin
            next_s = d;
        end
    end

    // Register update with synchronous reset to a bubble at address 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_r.instruction <= NOP_INSTR;
            q_r.pc          <= 12'd0;
            q_r.pc_plus1    <= 12'd1;
            q_r.valid       <= 1'b0;
        end else begin
            q_r <= next_s;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the program counter, captures the instruction word read
// combinationally from memory into IF/ID, and applies stall / redirect.
// PCAdd_pc comes straight from the PC register so stall/redirect never
// reach the memory address combinationally.
module fetch_stage
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [PC_W-1:0]    PCAdd_pc,
    input  logic [INSTR_W-1:0] M_instruction,
    output logic [INSTR_W-1:0] IFID_instruction,
    output logic [PC_W-1:0]    IFID_pc,
    output logic [PC_W-1:0]    IFID_pc_plus1,
    output logic               IFID_valid,
    output logic [CNT_W-1:0]   fetch_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [PC_W-1:0]  pc_r;
    logic [PC_W-1:0]  pc_next_s;
    logic [PC_W-1:0]  pc_plus1_s;
    logic [CNT_W-1:0] fetch_count_r;
    logic [CNT_W-1:0] count_next_s;
    logic             hold_s;
    logic             load_s;
    ifid_t            ifid_d_s;
    ifid_t            ifid_q_s;

    // Decode the edge action: redirect outranks stall.
    always_comb begin
        pc_plus1_s = pc_r + 12'd1;
        hold_s     = 1'b0;
        load_s     = 1'b0;
        pc_next_s  = pc_r;
        if (redirect) begin
            pc_next_s = redirect_pc;
        end else if (stall) begin
            hold_s    = 1'b1;
            pc_next_s = pc_r;
        end else begin
            load_s    = 1'b1;
            pc_next_s = pc_plus1_s;
        end
    end

    // Saturating count of real instructions latched into IF/ID.
    always_comb begin
        count_next_s = fetch_count_r;
        if (load_s && (fetch_count_r != CNT_MAX)) begin
            count_next_s = fetch_count_r + 16'd1;
        end else begin
            count_next_s = fetch_count_r;
        end
    end

    // Record presented to IF/ID on a normal fetch.
    always_comb begin
        ifid_d_s.instruction = M_instruction;
        ifid_d_s.pc          = pc_r;
        ifid_d_s.pc_plus1    = pc_plus1_s;
        ifid_d_s.valid       = 1'b1;
    end

    // PC and counter registers; reset overrides any redirect or stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r          <= 12'd0;
            fetch_count_r <= 16'd0;
        end else begin
            pc_r          <= pc_next_s;
            fetch_count_r <= count_next_s;
        end
    end

    if_id_reg u_if_id_reg (
        .clk   (clk),
        .reset (reset),
        .hold  (hold_s),
        .flush (redirect),
        .d     (ifid_d_s),
        .q     (ifid_q_s)
    );

    assign PCAdd_pc         = pc_r;
    assign fetch_count      = fetch_count_r;
    assign IFID_instruction = ifid_q_s.instruction;
    assign IFID_pc          = ifid_q_s.pc;
    assign IFID_pc_plus1    = ifid_q_s.pc_plus1;
    assign IFID_valid       = ifid_q_s.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a combinational instruction memory.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [11:0] redirect_pc;
    logic [11:0] PCAdd_pc;
    logic [15:0] M_instruction;
    logic [15:0] IFID_instruction;
    logic [11:0] IFID_pc;
    logic [11:0] IFID_pc_plus1;
    logic        IFID_valid;
    logic [15:0] fetch_count;

    logic [15:0] instM [0:4095];
    int n_checks = 0;
    int n_fail   = 0;

    fetch_stage dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .PCAdd_pc         (PCAdd_pc),
        .M_instruction    (M_instruction),
        .IFID_instruction (IFID_instruction),
        .IFID_pc          (IFID_pc),
        .IFID_pc_plus1    (IFID_pc_plus1),
        .IFID_valid       (IFID_valid),
        .fetch_count      (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign M_instruction = instM[PCAdd_pc];

    // Advance one edge and settle before sampling / driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare every visible field against expected values.
    task automatic check_all(input string nm, input logic [11:0] e_pc,
                             input logic [15:0] e_ins, input logic [11:0] e_ipc,
                             input logic [11:0] e_ipc1, input logic e_v,
                             input logic [15:0] e_cnt);
        n_checks++;
        if (PCAdd_pc !== e_pc) begin
            n_fail++; $display("FAIL %s pc: got %0d want %0d", nm, PCAdd_pc, e_pc);
        end
        n_checks++;
        if (IFID_instruction !== e_ins) begin
            n_fail++; $display("FAIL %s instr: got %h want %h", nm, IFID_instruction, e_ins);
        end
        n_checks++;
        if (IFID_pc !== e_ipc) begin
            n_fail++; $display("FAIL %s ifid_pc: got %0d want %0d", nm, IFID_pc, e_ipc);
        end
        n_checks++;
        if (IFID_pc_plus1 !== e_ipc1) begin
            n_fail++; $display("FAIL %s ifid_pc_plus1: got %0d want %0d", nm, IFID_pc_plus1, e_ipc1);
        end
        n_checks++;
        if (IFID_valid !== e_v) begin
            n_fail++; $display("FAIL %s valid: got %b want %b", nm, IFID_valid, e_v);
        end
        n_checks++;
        if (fetch_count !== e_cnt) begin
            n_fail++; $display("FAIL %s count: got %0d want %0d", nm, fetch_count, e_cnt);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 12'd0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        check_all("reset", 12'd0, 16'h6808, 12'd0, 12'd1, 1'b0, 16'd0);
    endtask

    task automatic test_normal();
        logic [15:0] exp_ins [0:3];
        exp_ins[0] = 16'h6141; exp_ins[1] = 16'h6242;
        exp_ins[2] = 16'h6313; exp_ins[3] = 16'h6414;
        for (int k = 1; k <= 4; k++) begin
            step();
            check_all("normal", 12'(k), exp_ins[k-1], 12'(k-1), 12'(k), 1'b1, 16'(k));
        end
    endtask

    task automatic test_stall();
        do_reset();
        step(); step(); step();
        check_all("pre_stall", 12'd3, 16'h6313, 12'd2, 12'd3, 1'b1, 16'd3);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_all("stall", 12'd3, 16'h6313, 12'd2, 12'd3, 1'b1, 16'd3);
        end
        stall = 1'b0;
        step();
        check_all("stall_release", 12'd4, 16'h6414, 12'd3, 12'd4, 1'b1, 16'd4);
    endtask

    task automatic test_redirect();
        step(); step();
        check_all("pre_redirect", 12'd6, 16'h5005, 12'd5, 12'd6, 1'b1, 16'd6);
        redirect = 1'b1; redirect_pc = 12'd6;
        step();
        check_all("redirect_bubble", 12'd6, 16'h6808, 12'd5, 12'd6, 1'b0, 16'd6);
        redirect = 1'b0;
        step();
        check_all("redirect_target", 12'd7, 16'h6142, 12'd6, 12'd7, 1'b1, 16'd7);
    endtask

    task automatic test_back_to_back();
        redirect = 1'b1; redirect_pc = 12'd10;
        step();
        check_all("b2b_first", 12'd10, 16'h6808, 12'd6, 12'd7, 1'b0, 16'd7);
        redirect_pc = 12'd20;
        step();
        check_all("b2b_second", 12'd20, 16'h6808, 12'd6, 12'd7, 1'b0, 16'd7);
        redirect = 1'b0;
        step();
        check_all("b2b_target", 12'd21, 16'h5014, 12'd20, 12'd21, 1'b1, 16'd8);
    endtask

    task automatic test_stall_redirect();
        stall = 1'b1; redirect = 1'b1; redirect_pc = 12'd0;
        step();
        check_all("stall_redirect", 12'd0, 16'h6808, 12'd20, 12'd21, 1'b0, 16'd8);
        stall = 1'b0; redirect = 1'b0;
        step();
        check_all("stall_redirect_after", 12'd1, 16'h6141, 12'd0, 12'd1, 1'b1, 16'd9);
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_pc = 12'd4095;
        step();
        check_all("wrap_redirect", 12'd4095, 16'h6808, 12'd0, 12'd1, 1'b0, 16'd9);
        redirect = 1'b0;
        step();
        check_all("wrap", 12'd0, 16'h5fff, 12'd4095, 12'd0, 1'b1, 16'd10);
    endtask

    task automatic test_reset_mid();
        step();
        reset = 1'b1; redirect = 1'b1; stall = 1'b1; redirect_pc = 12'd100;
        step();
        check_all("reset_mid", 12'd0, 16'h6808, 12'd0, 12'd1, 1'b0, 16'd0);
        reset = 1'b0; redirect = 1'b0; stall = 1'b0;
        step();
        check_all("reset_mid_after", 12'd1, 16'h6141, 12'd0, 12'd1, 1'b1, 16'd1);
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < 65534; k++) step();
        n_checks++;
        if (fetch_count !== 16'hfffe) begin
            n_fail++; $display("FAIL sat_pre count: got %h want fffe", fetch_count);
        end
        step();
        n_checks++;
        if (fetch_count !== 16'hffff) begin
            n_fail++; $display("FAIL sat_reach count: got %h want ffff", fetch_count);
        end
        for (int k = 0; k < 3; k++) step();
        check_all("sat_hold", 12'd2, 16'h6242, 12'd1, 12'd2, 1'b1, 16'hffff);
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Test sequence.
    initial begin
        for (int i = 0; i < 4096; i++) instM[i] = {4'h5, 12'(i)};
        instM[0] = 16'h6141; instM[1] = 16'h6242;
        instM[2] = 16'h6313; instM[3] = 16'h6414;
        instM[6] = 16'h6142;
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 12'd0;
        test_reset();
        test_normal();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_stall_redirect();
        test_wrap();
        test_reset_mid();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
